// File: rtl/biquad_cascade.sv
// Cascaded Direct Form I biquad sections sharing one multiplier; one product per cycle,
// five taps plus one round/saturate/history-update cycle per stage.
module biquad_cascade #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 18,
  parameter int COEF_FRAC  = 14,
  parameter int N_STAGES   = 4,
  parameter int STAGE_BITS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         start,
  output logic                         ready,
  output logic signed [DATA_WIDTH-1:0] sample_out,
  output logic                         done,
  input  logic signed [COEF_WIDTH-1:0] param_in,
  input  logic [STAGE_BITS-1:0]        param_stage,
  input  logic [2:0]                   param_target,
  input  logic                         write_param,
  input  logic [N_STAGES-1:0]          stage_bypass,
  input  logic                         clear_state
);

  localparam int ACC_W = DATA_WIDTH + COEF_WIDTH + 3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MAC    = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;

  localparam logic [STAGE_BITS-1:0] LAST_STAGE = STAGE_BITS'(N_STAGES - 1);

  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE  = COEF_WIDTH'(1) << COEF_FRAC;
  localparam logic signed [DATA_WIDTH-1:0] DATA_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] DATA_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]      SAT_MAX   = ACC_W'(DATA_MAX);
  localparam logic signed [ACC_W-1:0]      SAT_MIN   = ACC_W'(DATA_MIN);
  localparam logic signed [ACC_W-1:0]      ROUND     = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0]      ACC_ZERO  = '0;

  logic [1:0]                   state_reg;
  logic                         ready_reg;
  logic                         done_reg;
  logic signed [DATA_WIDTH-1:0] sample_out_reg;
  logic signed [DATA_WIDTH-1:0] u_reg;
  logic [STAGE_BITS-1:0]        stage_reg;
  logic [2:0]                   tap_reg;
  logic                         bypass_reg;
  logic signed [ACC_W-1:0]      acc_reg;

  logic signed [ACC_W-1:0]      acc_next;
  logic signed [ACC_W-1:0]      prod;
  logic signed [ACC_W-1:0]      acc_round;
  logic signed [ACC_W-1:0]      acc_shift;
  logic signed [DATA_WIDTH-1:0] y_sat;
  logic signed [DATA_WIDTH-1:0] y_next;
  logic signed [COEF_WIDTH-1:0] coef_sel;
  logic signed [DATA_WIDTH-1:0] operand;

  logic signed [COEF_WIDTH-1:0] tap_coef [N_STAGES];
  logic signed [DATA_WIDTH-1:0] tap_hist [N_STAGES];

  logic hist_clear;
  logic hist_shift;
  logic coef_write;

  assign hist_clear = ready_reg && clear_state;
  assign hist_shift = (state_reg == S_UPDATE) && !bypass_reg;
  assign coef_write = ready_reg && write_param && (param_target <= 3'd4);

  // Per-stage coefficient bank and history; each stage presents the operands for the current tap.
  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
    localparam logic [STAGE_BITS-1:0] IDX = STAGE_BITS'(gi);

    logic signed [DATA_WIDTH-1:0] x1_reg, x2_reg, y1_reg, y2_reg;
    logic signed [COEF_WIDTH-1:0] coef_reg [5];

    always_ff @(posedge clk) begin
      if (reset) begin
        x1_reg <= '0;
        x2_reg <= '0;
        y1_reg <= '0;
        y2_reg <= '0;
        for (int t = 0; t < 5; t++) begin
          coef_reg[t] <= (t == 0) ? COEF_ONE : '0;
        end
      end else begin
        if (hist_clear) begin
          x1_reg <= '0;
          x2_reg <= '0;
          y1_reg <= '0;
          y2_reg <= '0;
        end else if (hist_shift && stage_reg == IDX) begin
          x2_reg <= x1_reg;
          x1_reg <= u_reg;
          y2_reg <= y1_reg;
          y1_reg <= y_next;
        end
        if (coef_write && param_stage == IDX) begin
          coef_reg[param_target] <= param_in;
        end
      end
    end

    assign tap_coef[gi] = coef_reg[tap_reg];
    assign tap_hist[gi] = (tap_reg == 3'd1) ? x1_reg :
                          (tap_reg == 3'd2) ? x2_reg :
                          (tap_reg == 3'd3) ? y1_reg : y2_reg;
  end

  // Feedback taps (a1, a2) are subtracted; the accumulator restarts on tap 0.
  always_comb begin
    coef_sel  = tap_coef[stage_reg];
    operand   = (tap_reg == 3'd0) ? u_reg : tap_hist[stage_reg];
    prod      = ACC_W'(coef_sel) * ACC_W'(operand);
    acc_next  = ((tap_reg == 3'd0) ? ACC_ZERO : acc_reg) + ((tap_reg >= 3'd3) ? -prod : prod);
    acc_round = acc_reg + ROUND;
    acc_shift = acc_round >>> COEF_FRAC;
    if (acc_shift > SAT_MAX) begin
      y_sat = DATA_MAX;
    end else if (acc_shift < SAT_MIN) begin
      y_sat = DATA_MIN;
    end else begin
      y_sat = acc_shift[DATA_WIDTH-1:0];
    end
    y_next = bypass_reg ? u_reg : y_sat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      ready_reg      <= 1'b1;
      done_reg       <= 1'b0;
      sample_out_reg <= '0;
      u_reg          <= '0;
      stage_reg      <= '0;
      tap_reg        <= '0;
      bypass_reg     <= 1'b0;
      acc_reg        <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            u_reg     <= sample_in;
            stage_reg <= '0;
            tap_reg   <= '0;
            ready_reg <= 1'b0;
            state_reg <= S_MAC;
          end
        end
        S_MAC: begin
          acc_reg <= acc_next;
          if (tap_reg == 3'd0) begin
            bypass_reg <= stage_bypass[stage_reg];
          end
          if (tap_reg == 3'd4) begin
            state_reg <= S_UPDATE;
          end else begin
            tap_reg <= tap_reg + 3'd1;
          end
        end
        S_UPDATE: begin
          u_reg <= y_next;
          if (stage_reg != LAST_STAGE) begin
            stage_reg <= stage_reg + 1'b1;
            tap_reg   <= '0;
            state_reg <= S_MAC;
          end else begin
            sample_out_reg <= y_next;
            done_reg       <= 1'b1;
            ready_reg      <= 1'b1;
            state_reg      <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign ready      = ready_reg;
  assign done       = done_reg;
  assign sample_out = sample_out_reg;

endmodule
